// File: rtl/frontpanel_spi_sequencer.sv
// Front panel SPI frame sequencer: TX/RX byte FIFOs, chip-select
// setup/hold/idle timing and one shift handshake per queued byte.
module frontpanel_spi_sequencer #(
   parameter int FIFO_DEPTH      = 32,
   parameter int CS_SETUP_CYCLES = 50,
   parameter int CS_HOLD_CYCLES  = 50,
   parameter int CS_IDLE_CYCLES  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       txfifo_wr_en,
   input  logic [7:0] txfifo_wr_data,
   input  logic       txfifo_wr_last,
   output logic       txfifo_full,
   input  logic       rxfifo_rd_en,
   output logic [7:0] rxfifo_rd_data,
   output logic       rxfifo_empty,
   input  logic       err_clear,
   output logic       tx_overflow,
   output logic       rx_overflow,
   output logic       busy,
   output logic       shift_en,
   output logic [7:0] shift_data,
   input  logic       shift_done,
   input  logic [7:0] rx_data,
   output logic       spi_cs_n
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CMAX0 = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                          CS_SETUP_CYCLES : CS_HOLD_CYCLES;
   localparam int CMAX  = (CMAX0 > CS_IDLE_CYCLES) ?
                          CMAX0 : CS_IDLE_CYCLES;
   localparam int CW    = $clog2(CMAX + 1);

   localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(CS_IDLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_WAIT,
      ST_ACTIVE,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_q;

   logic [8:0]    tx_mem [FIFO_DEPTH];
   logic [AW:0]   tx_wptr;
   logic [AW:0]   tx_rptr;
   logic          tx_empty;
   logic          tx_push;
   logic          tx_pop;
   logic [8:0]    tx_head;

   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW:0]   rx_wptr;
   logic [AW:0]   rx_rptr;
   logic          rx_full;
   logic          rx_req;
   logic          rx_push;
   logic          rx_pop;

   assign tx_empty    = (tx_wptr == tx_rptr);
   assign txfifo_full = (tx_wptr[AW] != tx_rptr[AW]) &&
                        (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
   assign tx_pop      = (state == ST_SHIFT) && !tx_empty;
   assign tx_push     = txfifo_wr_en && (!txfifo_full || tx_pop);
   assign tx_head     = tx_mem[tx_rptr[AW-1:0]];

   assign rxfifo_empty = (rx_wptr == rx_rptr);
   assign rx_full      = (rx_wptr[AW] != rx_rptr[AW]) &&
                         (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
   assign rx_req       = (state == ST_WAIT) && shift_done;
   assign rx_pop       = rxfifo_rd_en && !rxfifo_empty;
   assign rx_push      = rx_req && (!rx_full || rx_pop);

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wptr[AW-1:0]] <= {txfifo_wr_last, txfifo_wr_data};
      if (rx_push)
         rx_mem[rx_wptr[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wptr        <= '0;
         tx_rptr        <= '0;
         rx_wptr        <= '0;
         rx_rptr        <= '0;
         rxfifo_rd_data <= 8'h00;
         tx_overflow    <= 1'b0;
         rx_overflow    <= 1'b0;
      end else begin
         if (tx_push)
            tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)
            tx_rptr <= tx_rptr + 1'b1;
         if (rx_push)
            rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop) begin
            rx_rptr        <= rx_rptr + 1'b1;
            rxfifo_rd_data <= rx_mem[rx_rptr[AW-1:0]];
         end
         // a fresh error in the clearing cycle keeps its flag set
         tx_overflow <= (tx_overflow && !err_clear) ||
                        (txfifo_wr_en && txfifo_full && !tx_pop);
         rx_overflow <= (rx_overflow && !err_clear) ||
                        (rx_req && rx_full && !rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_q     <= 1'b0;
         spi_cs_n   <= 1'b1;
         shift_en   <= 1'b0;
         shift_data <= 8'h00;
      end else begin
         shift_en <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!tx_empty) begin
                  spi_cs_n <= 1'b0;
                  cnt      <= SETUP_LD;
                  state    <= (CS_SETUP_CYCLES == 1) ? ST_SHIFT : ST_SETUP;
               end
            end
            ST_SETUP: begin
               // leaving one cycle early lets SHIFT register shift_en on time
               if (cnt <= CW'(1))
                  state <= ST_SHIFT;
               else
                  cnt <= cnt - CW'(1);
            end
            ST_SHIFT: begin
               shift_en   <= 1'b1;
               shift_data <= tx_head[7:0];
               last_q     <= tx_head[8];
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (shift_done) begin
                  if (last_q) begin
                     cnt   <= HOLD_LD;
                     state <= ST_HOLD;
                  end else if (!tx_empty) begin
                     state <= ST_SHIFT;
                  end else begin
                     state <= ST_ACTIVE;
                  end
               end
            end
            ST_ACTIVE: begin
               if (!tx_empty)
                  state <= ST_SHIFT;
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  spi_cs_n <= 1'b1;
                  cnt      <= GAP_LD;
                  state    <= ST_GAP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_GAP: begin
               if (cnt == '0)
                  state <= ST_IDLE;
               else
                  cnt <= cnt - CW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frontpanel_spi_sequencer.sv
// Directed bench for frontpanel_spi_sequencer with a small SPI host
// responder that answers each byte with byte ^ 0x99.
module tb_frontpanel_spi_sequencer;

   localparam int SPI_LAT = 8;

   logic       clk;
   logic       rst;
   logic       txfifo_wr_en;
   logic [7:0] txfifo_wr_data;
   logic       txfifo_wr_last;
   logic       txfifo_full;
   logic       rxfifo_rd_en;
   logic [7:0] rxfifo_rd_data;
   logic       rxfifo_empty;
   logic       err_clear;
   logic       tx_overflow;
   logic       rx_overflow;
   logic       busy;
   logic       shift_en;
   logic [7:0] shift_data;
   logic       shift_done;
   logic [7:0] rx_data;
   logic       spi_cs_n;

   int checks;
   int errors;
   int cyc;
   logic stall;
   logic prev_cs;

   int        fall_q[$];
   int        rise_q[$];
   int        se_q[$];
   int        done_q[$];
   logic [7:0] sent_q[$];

   frontpanel_spi_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .txfifo_wr_en   (txfifo_wr_en),
      .txfifo_wr_data (txfifo_wr_data),
      .txfifo_wr_last (txfifo_wr_last),
      .txfifo_full    (txfifo_full),
      .rxfifo_rd_en   (rxfifo_rd_en),
      .rxfifo_rd_data (rxfifo_rd_data),
      .rxfifo_empty   (rxfifo_empty),
      .err_clear      (err_clear),
      .tx_overflow    (tx_overflow),
      .rx_overflow    (rx_overflow),
      .busy           (busy),
      .shift_en       (shift_en),
      .shift_data     (shift_data),
      .shift_done     (shift_done),
      .rx_data        (rx_data),
      .spi_cs_n       (spi_cs_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial prev_cs = 1'b1;
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_cs && !spi_cs_n) fall_q.push_back(cyc);
         if (!prev_cs && spi_cs_n) rise_q.push_back(cyc);
         if (shift_en) se_q.push_back(cyc);
      end
      prev_cs = spi_cs_n;
   end

   // SPI host stand-in; done_q holds the DUT edge that samples shift_done
   initial begin
      logic [7:0] b;
      shift_done = 1'b0;
      rx_data    = 8'h00;
      forever begin
         @(negedge clk);
         if (shift_en && !rst) begin
            b = shift_data;
            sent_q.push_back(b);
            repeat (SPI_LAT) @(negedge clk);
            while (stall) @(negedge clk);
            shift_done = 1'b1;
            rx_data    = b ^ 8'h99;
            done_q.push_back(cyc + 1);
            @(negedge clk);
            shift_done = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      fall_q.delete();
      rise_q.delete();
      se_q.delete();
      done_q.delete();
      sent_q.delete();
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      txfifo_wr_en   = 1'b1;
      txfifo_wr_data = d;
      txfifo_wr_last = l;
      @(negedge clk);
      txfifo_wr_en   = 1'b0;
   endtask

   task automatic pop(output logic [7:0] d);
      rxfifo_rd_en = 1'b1;
      @(negedge clk);
      rxfifo_rd_en = 1'b0;
      d = rxfifo_rd_data;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int t;
      t = 0;
      while ((rise_q.size() < n || busy) && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("frame_done", rise_q.size(), n);
   endtask

   initial begin
      logic [7:0] d;
      checks = 0;
      errors = 0;
      stall  = 1'b0;
      rst    = 1'b1;
      txfifo_wr_en   = 1'b0;
      txfifo_wr_data = 8'h00;
      txfifo_wr_last = 1'b0;
      rxfifo_rd_en   = 1'b0;
      err_clear      = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_cs_n", spi_cs_n, 1);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_shift_data", shift_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_full", txfifo_full, 0);
      chk("rst_rx_empty", rxfifo_empty, 1);
      chk("rst_tx_ovf", tx_overflow, 0);
      chk("rst_rx_ovf", rx_overflow, 0);
      chk("rst_rd_data", rxfifo_rd_data, 0);

      // single byte frame
      clr();
      push(8'hA5, 1'b1);
      wait_frames(1, 1000);
      chk("t1_shifts", se_q.size(), 1);
      chk("t1_data", sent_q[0], 8'hA5);
      chk("t1_setup", se_q[0] - fall_q[0], 50);
      chk("t1_hold", rise_q[0] - done_q[0], 50);
      chk("t1_rx_nonempty", rxfifo_empty, 0);
      pop(d);
      chk("t1_rx", d, 8'h3C);
      chk("t1_rx_empty", rxfifo_empty, 1);

      // three byte frame
      clr();
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h03, 1'b1);
      wait_frames(1, 2000);
      chk("t2_falls", fall_q.size(), 1);
      chk("t2_shifts", se_q.size(), 3);
      chk("t2_gap1", se_q[1] - done_q[0], 1);
      chk("t2_gap2", se_q[2] - done_q[1], 1);
      chk("t2_hold", rise_q[0] - done_q[2], 50);
      for (int i = 0; i < 3; i++) begin
         pop(d);
         chk("t2_rx", d, (8'(i + 1)) ^ 8'h99);
      end

      // frame held open in ACTIVE
      clr();
      push(8'h10, 1'b0);
      repeat (1000) @(negedge clk);
      chk("t3_cs_low", spi_cs_n, 0);
      chk("t3_busy", busy, 1);
      chk("t3_no_rise", rise_q.size(), 0);
      push(8'h11, 1'b1);
      wait_frames(1, 1000);
      chk("t3_falls", fall_q.size(), 1);
      chk("t3_shifts", se_q.size(), 2);
      pop(d);
      chk("t3_rx0", d, 8'h89);
      pop(d);
      chk("t3_rx1", d, 8'h88);

      // back-to-back frames
      clr();
      push(8'h20, 1'b1);
      push(8'h21, 1'b1);
      wait_frames(2, 2000);
      chk("t4_falls", fall_q.size(), 2);
      chk("t4_idle_min", (fall_q[1] - rise_q[0]) >= 100, 1);
      chk("t4_sent0", sent_q[0], 8'h20);
      chk("t4_sent1", sent_q[1], 8'h21);
      pop(d);
      chk("t4_rx0", d, 8'hB9);
      pop(d);
      chk("t4_rx1", d, 8'hB8);

      // FIFO limits and sticky errors
      clr();
      stall = 1'b1;
      for (int i = 0; i < 32; i++)
         push(8'(8'h40 + i), i == 31);
      chk("t5_full", txfifo_full, 1);
      chk("t5_no_tx_ovf", tx_overflow, 0);
      push(8'hEE, 1'b1);
      chk("t5_tx_ovf", tx_overflow, 1);
      stall = 1'b0;
      wait_frames(1, 3000);
      chk("t5_shifts", se_q.size(), 32);
      chk("t5_last_sent", sent_q[31], 8'h5F);
      chk("t5_no_rx_ovf", rx_overflow, 0);
      push(8'h77, 1'b1);
      wait_frames(2, 1000);
      chk("t5_rx_ovf", rx_overflow, 1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("t5_clr_tx", tx_overflow, 0);
      chk("t5_clr_rx", rx_overflow, 0);
      for (int i = 0; i < 32; i++) begin
         pop(d);
         chk("t5_rx", d, (8'(8'h40 + i)) ^ 8'h99);
      end
      chk("t5_rx_empty", rxfifo_empty, 1);
      pop(d);
      chk("t5_pop_empty", d, 8'hC6);

      // reset during WAIT of a 4-byte frame
      clr();
      push(8'h31, 1'b0);
      push(8'h32, 1'b0);
      push(8'h33, 1'b0);
      push(8'h34, 1'b1);
      for (int t = 0; t < 500 && se_q.size() < 2; t++)
         @(negedge clk);
      chk("t6_reached", se_q.size(), 2);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_cs_n", spi_cs_n, 1);
      chk("t6_busy", busy, 0);
      chk("t6_tx_full", txfifo_full, 0);
      chk("t6_rx_empty", rxfifo_empty, 1);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("t6_still_idle", busy, 0);
      clr();
      push(8'h55, 1'b1);
      wait_frames(1, 1000);
      chk("t6_shifts", se_q.size(), 1);
      chk("t6_sent", sent_q[0], 8'h55);
      pop(d);
      chk("t6_rx", d, 8'hCC);
      chk("t6_rx_empty", rxfifo_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
